// File: rtl/decode_in_trace_buffer.sv
// Purpose : capture buffer for the LC3 decode-stage input bus; each sample is timestamped and queued for a valid/ready consumer.
// Latency : a sample taken at edge N is visible on out_* after edge N when the queue was empty; no bypass.
// Backpress: out_ready low holds the head. Captures into a full queue are dropped and counted in overflow_cnt (saturating).
//
// Ports: clock/reset (async active-low); capture_en, mode, flush control capture;
//        enable_decode/instr_dout/npc_in/psr are the sampled decode bus;
//        out_valid/out_ready plus out_* form the first-word-fall-through head;
//        count/full/empty/overflow_cnt report occupancy and dropped captures.
module decode_in_trace_buffer #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int PSR_W   = 3,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     mode,
    input  logic                     flush,
    input  logic                     enable_decode,
    input  logic [INSTR_W-1:0]       instr_dout,
    input  logic [PC_W-1:0]          npc_in,
    input  logic [PSR_W-1:0]         psr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_enable,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_npc,
    output logic [PSR_W-1:0]         out_psr,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic               en;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    npc;
        logic [PSR_W-1:0]   psr;
        logic [TS_W-1:0]    ts;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          wr_entry;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TS_W-1:0] ts;

    logic push_req;
    logic do_pop;
    logic do_write;
    logic do_drop;

    // flush masks both sides, so it wins over any push or pop in that cycle
    assign push_req = capture_en & (~mode | enable_decode) & ~flush;
    assign do_pop   = out_valid & out_ready & ~flush;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    assign do_write = push_req & (~full | do_pop);
    assign do_drop  = push_req & full & ~do_pop;

    assign wr_entry = '{en: enable_decode, instr: instr_dout, npc: npc_in, psr: psr, ts: ts};

    // free-running timestamp; flush deliberately leaves it alone
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // storage carries no reset: contents are only observable while count>0
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_write && do_pop) begin
                count <= count - 1'b1;
            end
            if (do_drop && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = ~empty;

    // head data is zeroed while empty so stale entries never leak out
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_enable = head.en;
    assign out_instr  = head.instr;
    assign out_npc    = head.npc;
    assign out_psr    = head.psr;
    assign out_ts     = head.ts;

endmodule

// File: tb/tb_decode_in_trace_buffer.sv
// Purpose : directed and randomised checks of decode_in_trace_buffer against hand-computed values and a queue model.
// Latency : inputs driven on negedge, sampled by the DUT on the next posedge, checked on the following negedge.
// Backpress: out_ready is driven explicitly per scenario; the queue model decides pops from its own occupancy.
module tb_decode_in_trace_buffer;

    typedef struct packed {
        logic        en;
        logic [15:0] instr;
        logic [15:0] npc;
        logic [2:0]  psr;
        logic [15:0] ts;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        capture_en;
    logic        mode;
    logic        flush;
    logic        enable_decode;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [2:0]  psr;
    logic        out_valid;
    logic        out_ready;
    logic        out_enable;
    logic [15:0] out_instr;
    logic [15:0] out_npc;
    logic [2:0]  out_psr;
    logic [15:0] out_ts;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [7:0]  overflow_cnt;

    int n_vec;
    int n_bad;

    // reference timestamp: counts edges since reset release
    logic [15:0] tb_ts;

    ent_t q[$];
    int   exp_ovf;

    decode_in_trace_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .capture_en    (capture_en),
        .mode          (mode),
        .flush         (flush),
        .enable_decode (enable_decode),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .psr           (psr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_enable    (out_enable),
        .out_instr     (out_instr),
        .out_npc       (out_npc),
        .out_psr       (out_psr),
        .out_ts        (out_ts),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_cnt  (overflow_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t head_now();
        return '{en: out_enable, instr: out_instr, npc: out_npc, psr: out_psr, ts: out_ts};
    endfunction

    task automatic drive(input logic cap, input logic md, input logic en,
                         input logic [15:0] ins, input logic [15:0] npc, input logic [2:0] p,
                         input logic rdy);
        capture_en    = cap;
        mode          = md;
        enable_decode = en;
        instr_dout    = ins;
        npc_in        = npc;
        psr           = p;
        out_ready     = rdy;
    endtask

    initial begin
        logic [15:0] t0;
        logic [15:0] te;
        logic        pop_m;
        logic        push_m;
        ent_t        e;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0, 3'h0, 0);

        // ---- reset state
        repeat (2) @(negedge clock);
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", head_now(), 0);
        check_eq("rst_ovf", overflow_cnt, 0);

        // ---- single capture at ts=5, mode=1
        reset = 1'b1;
        for (int i = 0; i < 20 && tb_ts != 16'd5; i++) @(negedge clock);
        check_eq("t1_ts_reached", tb_ts, 16'd5);
        drive(1, 1, 1, 16'h1234, 16'h3001, 3'b010, 0);
        @(negedge clock);
        drive(1, 1, 0, 16'hdead, 16'hbeef, 3'b111, 0);
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_head", head_now(), {1'b1, 16'h1234, 16'h3001, 3'b010, 16'd5});
        check_eq("t1_count", count, 1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check_eq("t1_pop_empty", empty, 1);

        // ---- mode 0 overflow: 10 pushes into 8 entries
        t0 = tb_ts;
        drive(1, 0, 0, 16'h0, 16'h0, 3'h0, 0);
        repeat (8) @(negedge clock);
        check_eq("t2_full8", full, 1);
        repeat (2) @(negedge clock);
        capture_en = 1'b0;
        check_eq("t2_count", count, 8);
        check_eq("t2_ovf", overflow_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_drain_ts", out_ts, t0 + 16'(i));
            @(negedge clock);
        end
        check_eq("t2_drained", empty, 1);
        drive(1, 1, 0, 16'h5555, 16'h0, 3'h0, 0);
        repeat (3) @(negedge clock);
        check_eq("t2_mode1_nocap", count, 0);

        // ---- full with simultaneous push and pop
        t0 = tb_ts;
        drive(1, 0, 0, 16'h0, 16'h0, 3'h0, 0);
        repeat (8) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        capture_en = 1'b0;
        check_eq("t3_count", count, 8);
        check_eq("t3_full", full, 1);
        check_eq("t3_ovf", overflow_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check_eq("t3_order_ts", out_ts, t0 + 16'(i + 1));
            @(negedge clock);
        end
        check_eq("t3_empty", empty, 1);

        // ---- saturation then flush
        drive(1, 0, 0, 16'h0, 16'h0, 3'h0, 0);
        repeat (308) @(negedge clock);
        check_eq("t4_ovf_sat", overflow_cnt, 255);
        check_eq("t4_count", count, 8);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        capture_en = 1'b0;
        check_eq("t4_fl_count", count, 0);
        check_eq("t4_fl_empty", empty, 1);
        check_eq("t4_fl_ovf", overflow_cnt, 0);
        check_eq("t4_fl_data", head_now(), 0);
        te = tb_ts;
        drive(1, 1, 1, 16'h0abc, 16'h4000, 3'b100, 0);
        @(negedge clock);
        capture_en = 1'b0;
        check_eq("t4_ts_runs", head_now(), {1'b1, 16'h0abc, 16'h4000, 3'b100, te});
        out_ready = 1'b1;
        @(negedge clock);

        // ---- asynchronous reset mid-stream
        drive(1, 0, 1, 16'h7777, 16'h1111, 3'b001, 0);
        repeat (5) @(negedge clock);
        check_eq("t5_count5", count, 5);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_async_count", count, 0);
        check_eq("t5_async_valid", out_valid, 0);
        check_eq("t5_async_data", head_now(), 0);
        @(negedge clock);
        reset = 1'b1;
        capture_en = 1'b0;
        repeat (3) @(negedge clock);
        capture_en = 1'b1;
        @(negedge clock);
        capture_en = 1'b0;
        check_eq("t5_first_ts", out_ts, 16'd3);
        check_eq("t5_count1", count, 1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;

        // ---- random stress against a queue model
        q.delete();
        exp_ovf = 0;
        for (int c = 0; c < 400; c++) begin
            check_eq("st_count", count, 64'(q.size()));
            check_eq("st_ovf", overflow_cnt, 64'(exp_ovf));
            if (q.size() > 0) check_eq("st_head", head_now(), q[0]);
            else              check_eq("st_head0", head_now(), 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 3'($urandom), $urandom_range(0, 9) < 4);
            pop_m  = (q.size() > 0) && out_ready;
            push_m = capture_en && (!mode || enable_decode);
            e = '{en: enable_decode, instr: instr_dout, npc: npc_in, psr: psr, ts: tb_ts};
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                if (q.size() < 8) q.push_back(e);
                else if (exp_ovf < 255) exp_ovf++;
            end
            @(negedge clock);
        end
        capture_en = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) @(negedge clock);
        check_eq("st_drained", empty, 1);
        out_ready = 1'b0;

        // ---- timestamp wrap 16'hFFFF -> 0
        for (int i = 0; i < 70000 && tb_ts != 16'hFFFE; i++) @(negedge clock);
        check_eq("wr_reached", tb_ts, 16'hFFFE);
        drive(1, 0, 0, 16'h0, 16'h0, 3'h0, 0);
        repeat (3) @(negedge clock);
        capture_en = 1'b0;
        check_eq("wr_ts0", out_ts, 16'hFFFE);
        out_ready = 1'b1;
        @(negedge clock);
        check_eq("wr_ts1", out_ts, 16'hFFFF);
        @(negedge clock);
        check_eq("wr_ts2", out_ts, 16'h0000);
        @(negedge clock);
        check_eq("wr_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_in_trace_buffer.md
# decode_in_trace_buffer

Synthesizable capture buffer for the LC3 decode-stage input bus. It samples enable_decode, instr_dout, npc_in and psr on qualifying clock edges, timestamps each sample, and queues it in a parametrised FIFO drained through a valid/ready port. It sits beside the decode stage as an on-chip trace source, the hardware successor to cycle-by-cycle sampling of the decode_in bus, with selectable capture mode, overflow accounting and flush.

## Interface
- INSTR_W, 16, instruction width
- PC_W, 16, npc width
- PSR_W, 3, psr width
- DEPTH, 8, FIFO entries; power of two, ≥2
- TS_W, 16, timestamp width
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low (0 = in reset)
- capture_en  in  1  global capture gate
- mode  in  1  0 = capture every cycle; 1 = capture only when enable_decode=1
- flush  in  1  synchronous clear of FIFO contents and overflow_cnt
- enable_decode  in  1  decode bus
- instr_dout  in  INSTR_W  decode bus
- npc_in  in  PC_W  decode bus
- psr  in  PSR_W  decode bus
- out_valid  out  1  head entry present
- out_ready  in  1  consumer accepts head
- out_enable  out  1  head enable_decode
- out_instr  out  INSTR_W  head instr_dout
- out_npc  out  PC_W  head npc_in
- out_psr  out  PSR_W  head psr
- out_ts  out  TS_W  head timestamp
- count  out  $clog2(DEPTH)+1  entries held
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow_cnt  out  8  dropped captures, saturating

## Operation
- Timestamp counter ts: 0 out of reset, +1 every clock, wraps 2^TS_W-1 → 0; unaffected by flush.
- push = capture_en & (mode==0 | enable_decode) & ~flush. Entry written = {enable_decode, instr_dout, npc_in, psr, ts} sampled at that edge (ts value before increment).
- pop = out_valid & out_ready & ~flush.
- Full: push with no pop → entry dropped, overflow_cnt +1, saturates at 255. Push and pop same cycle while full → both occur, no drop, count unchanged.
- Empty: push with pop request impossible (out_valid=0); no bypass.
- Push+pop when 0<count<DEPTH → count unchanged, pointers both advance.
- flush=1: pointers and count to 0, overflow_cnt to 0; push/pop that cycle ignored. Takes priority over everything.
- Pointers $clog2(DEPTH) bits, wrap naturally; count tracked separately.
- Output is first-word-fall-through: out_* reflect head entry whenever out_valid=1; when empty out_* data forced to 0.
- Consumer may hold out_ready high continuously; one entry per cycle maximum.

## Timing
- Reset (async assert, sync release): count=0, empty=1, full=0, out_valid=0, all out_* data 0, overflow_cnt=0, ts=0.
- Capture latency: sample at edge N → out_valid=1 after edge N (visible in cycle N+1) if FIFO was empty.
- Pop at edge N → next entry (or empty) visible after edge N.
- count/full/empty/overflow_cnt registered, update on the same edge as push/pop.
- Reset asserted mid-operation: all state cleared immediately, contents lost; first capture possible on first edge after release.
- Inputs sampled only at posedge; no combinational path from decode bus to outputs; out_ready → internal pop only (no combinational out_ready→out_valid path).

## Test plan
- Reset release, mode=1, capture_en=1, enable_decode pulses with instr_dout=16'h1234, npc_in=16'h3001, psr=3'b010 at ts=5 → out_valid next cycle, out_instr=16'h1234, out_npc=16'h3001, out_psr=3'b010, out_ts=5, count=1.
- mode=0, out_ready=0, 10 consecutive cycles, DEPTH=8 → full=1 after 8, overflow_cnt=2, drained entries show consecutive ts values; mode=1 with enable_decode=0 → no captures.
- Full FIFO, push and out_ready=1 same cycle → count stays 8, overflow_cnt unchanged, new entry appears last in order.
- Drive 300 drops with out_ready=0 → overflow_cnt saturates at 255; flush → count=0, empty=1, overflow_cnt=0, out data 0, ts keeps counting.
- Assert reset low mid-stream with count=5 → outputs return to reset values asynchronously; after release, first capture yields out_ts equal to cycles since release.
- Random push/out_ready stress against a queue model → order, data and count always match; ts wrap from 16'hFFFF to 0 captured correctly.
